// File: rtl/issue_scoreboard_pkg.sv
// Shared types and defaults for the N-wide in-order issue stage.
// Holds default lane/register counts, the decoded slot record and the
// hard-zero register index used by hazard checks.
package ss_pkg;

   localparam int ISSUE_WIDTH_DEF = 2;
   localparam int NUM_REGS_DEF    = 32;
   localparam int WB_PORTS_DEF    = 2;
   localparam int RW_DEF          = $clog2(NUM_REGS_DEF);

   // One decode slot as presented by decode.
   typedef struct packed {
      logic              valid;
      logic [RW_DEF-1:0] rs1;
      logic [RW_DEF-1:0] rs2;
      logic [RW_DEF-1:0] rd;
      logic              we;
   } slot_t;

   // Register 0 reads as zero: never a hazard, never marked pending.
   localparam logic [RW_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Bus between decode/writeback/execute and the issue scoreboard.
// master: decode + writeback + execute side (drives lanes, wb, stall, flush).
// slave : issue stage (returns issue_cnt, registered bundle, scoreboard).
interface issue_scoreboard_if
   import ss_pkg::*;
#(
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int WB_PORTS    = WB_PORTS_DEF
);
   localparam int RW = $clog2(NUM_REGS);
   localparam int CW = $clog2(ISSUE_WIDTH + 1);

   // decode bundle
   logic [ISSUE_WIDTH-1:0]    lane_valid;
   logic [ISSUE_WIDTH*RW-1:0] lane_rs1;
   logic [ISSUE_WIDTH*RW-1:0] lane_rs2;
   logic [ISSUE_WIDTH*RW-1:0] lane_rd;
   logic [ISSUE_WIDTH-1:0]    lane_we;
   // execute control
   logic                      ex_stall;
   logic                      flush;
   // writeback
   logic [WB_PORTS-1:0]       wb_valid;
   logic [WB_PORTS*RW-1:0]    wb_rd;
   // issue results
   logic [CW-1:0]             issue_cnt;
   logic [ISSUE_WIDTH-1:0]    iss_valid;
   logic [ISSUE_WIDTH*RW-1:0] iss_rs1;
   logic [ISSUE_WIDTH*RW-1:0] iss_rs2;
   logic [ISSUE_WIDTH*RW-1:0] iss_rd;
   logic [ISSUE_WIDTH-1:0]    iss_we;
   logic [NUM_REGS-1:0]       pending;
   logic [31:0]               hazard_stall_cnt;

   modport master (
      output lane_valid, lane_rs1, lane_rs2, lane_rd, lane_we,
      output ex_stall, flush, wb_valid, wb_rd,
      input  issue_cnt, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we,
      input  pending, hazard_stall_cnt
   );

   modport slave (
      input  lane_valid, lane_rs1, lane_rs2, lane_rd, lane_we,
      input  ex_stall, flush, wb_valid, wb_rd,
      output issue_cnt, iss_valid, iss_rs1, iss_rs2, iss_rd, iss_we,
      output pending, hazard_stall_cnt
   );

endinterface

// File: rtl/issue_hazard_check.sv
// Per-lane hazard check: slot may issue if valid and free of scoreboard
// and intra-bundle RAW/WAW conflicts. Purely combinational, no backpressure.
// Ports: valid_i/rs1_i/rs2_i/rd_i/we_i = this slot; prev_rd_i/prev_we_i =
// all bundle slots with prev_we_i already masked to earlier slots only;
// eff_i = effective pending vector; ok_o = slot is hazard-free and valid.
module issue_hazard_check
   import ss_pkg::*;
#(
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int RW          = $clog2(NUM_REGS)
) (
   input  logic                      valid_i,
   input  logic [RW-1:0]             rs1_i,
   input  logic [RW-1:0]             rs2_i,
   input  logic [RW-1:0]             rd_i,
   input  logic                      we_i,
   input  logic [ISSUE_WIDTH*RW-1:0] prev_rd_i,
   input  logic [ISSUE_WIDTH-1:0]    prev_we_i,
   input  logic [NUM_REGS-1:0]       eff_i,
   output logic                      ok_o
);

   localparam logic [RW-1:0] ZR = RW'(ZERO_REG);

   logic          hit;
   logic [RW-1:0] prd;

   always_comb begin
      hit = 1'b0;
      prd = '0;
      // Outstanding writes in the scoreboard.
      if (rs1_i != ZR && eff_i[rs1_i]) hit = 1'b1;
      if (rs2_i != ZR && eff_i[rs2_i]) hit = 1'b1;
      if (we_i && rd_i != ZR && eff_i[rd_i]) hit = 1'b1;
      // Earlier slots of the same bundle (later slots have we masked off).
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
         prd = prev_rd_i[j*RW +: RW];
         if (prev_we_i[j] && prd != ZR) begin
            if (prd == rs1_i || prd == rs2_i) hit = 1'b1;
            if (we_i && prd == rd_i)          hit = 1'b1;
         end
      end
   end

   // AND with valid so an idle slot carrying X indices reads as not-ok.
   assign ok_o = valid_i & ~hit;

endmodule

// File: rtl/issue_scoreboard.sv
// N-wide in-order issue stage with register scoreboard.
// Latency: issue_cnt combinational, issued bundle registered (1 cycle).
// Backpressure: ex_stall holds the bundle and issues nothing; flush kills it.
// Ports: clk, rst (async active-high); bus (slave modport) carries decode
// lanes, ex_stall/flush, writeback ports, issue_cnt, registered iss_*,
// pending scoreboard and hazard_stall_cnt.
// Build option WB_BYPASS_EN: registers written back this cycle do not
// block issue in the same cycle.
module issue_scoreboard
   import ss_pkg::*;
#(
   parameter int ISSUE_WIDTH = ISSUE_WIDTH_DEF,
   parameter int NUM_REGS    = NUM_REGS_DEF,
   parameter int WB_PORTS    = WB_PORTS_DEF
) (
   input  logic               clk,
   input  logic               rst,
   issue_scoreboard_if.slave  bus
);

   localparam int RW = $clog2(NUM_REGS);
   localparam int CW = $clog2(ISSUE_WIDTH + 1);

   logic [NUM_REGS-1:0]       pending_q, pending_d, eff;
   logic [ISSUE_WIDTH-1:0]    iss_valid_q, iss_valid_d;
   logic [ISSUE_WIDTH-1:0]    iss_we_q, iss_we_d;
   logic [ISSUE_WIDTH*RW-1:0] iss_rs1_q, iss_rs1_d;
   logic [ISSUE_WIDTH*RW-1:0] iss_rs2_q, iss_rs2_d;
   logic [ISSUE_WIDTH*RW-1:0] iss_rd_q, iss_rd_d;
   logic [31:0]               hz_cnt_q, hz_cnt_d;

   logic [ISSUE_WIDTH-1:0]    ok;
   logic [ISSUE_WIDTH-1:0]    issue_mask;
   logic [CW-1:0]             issue_cnt;
   logic                      run;

   // Effective pending seen by the hazard checks.
   always_comb begin
      eff = pending_q;
`ifdef WB_BYPASS_EN
      for (int p = 0; p < WB_PORTS; p++)
         if (bus.wb_valid[p]) eff[bus.wb_rd[p*RW +: RW]] = 1'b0;
`endif
   end

   for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_lane
      // Only slots ahead of lane k can create intra-bundle hazards for it.
      localparam logic [ISSUE_WIDTH-1:0] EARLIER = ISSUE_WIDTH'((1 << k) - 1);

      issue_hazard_check #(
         .ISSUE_WIDTH (ISSUE_WIDTH),
         .NUM_REGS    (NUM_REGS),
         .RW          (RW)
      ) u_chk (
         .valid_i   (bus.lane_valid[k]),
         .rs1_i     (bus.lane_rs1[k*RW +: RW]),
         .rs2_i     (bus.lane_rs2[k*RW +: RW]),
         .rd_i      (bus.lane_rd[k*RW +: RW]),
         .we_i      (bus.lane_we[k]),
         .prev_rd_i (bus.lane_rd),
         .prev_we_i (bus.lane_we & EARLIER),
         .eff_i     (eff),
         .ok_o      (ok[k])
      );
   end

   // In-order prefix: the first blocked or empty slot stops everything behind it.
   always_comb begin
      run        = !rst && !bus.ex_stall && !bus.flush;
      issue_mask = '0;
      issue_cnt  = '0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         run           = run & ok[k];
         issue_mask[k] = run;
         if (run) issue_cnt = issue_cnt + 1'b1;
      end
   end

   // Scoreboard: writeback clears, then flush-kill clears, then issue sets
   // (so a set beats a clear on the same register).
   always_comb begin
      pending_d = pending_q;
      for (int p = 0; p < WB_PORTS; p++)
         if (bus.wb_valid[p]) pending_d[bus.wb_rd[p*RW +: RW]] = 1'b0;
      if (bus.flush)
         for (int k = 0; k < ISSUE_WIDTH; k++)
            if (iss_valid_q[k] && iss_we_q[k]) pending_d[iss_rd_q[k*RW +: RW]] = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++)
         if (issue_mask[k] && bus.lane_we[k]) pending_d[bus.lane_rd[k*RW +: RW]] = 1'b1;
      pending_d[0] = 1'b0;
   end

   // Issue register: flush beats stall; non-issued lanes load zeros.
   always_comb begin
      iss_valid_d = iss_valid_q;
      iss_we_d    = iss_we_q;
      iss_rs1_d   = iss_rs1_q;
      iss_rs2_d   = iss_rs2_q;
      iss_rd_d    = iss_rd_q;
      if (bus.flush) begin
         iss_valid_d = '0;
      end else if (!bus.ex_stall) begin
         iss_valid_d = issue_mask;
         iss_we_d    = bus.lane_we & issue_mask;
         for (int k = 0; k < ISSUE_WIDTH; k++) begin
            iss_rs1_d[k*RW +: RW] = issue_mask[k] ? bus.lane_rs1[k*RW +: RW] : '0;
            iss_rs2_d[k*RW +: RW] = issue_mask[k] ? bus.lane_rs2[k*RW +: RW] : '0;
            iss_rd_d[k*RW +: RW]  = issue_mask[k] ? bus.lane_rd[k*RW +: RW]  : '0;
         end
      end
   end

   // Saturating count of cycles where a valid head slot was hazard-blocked.
   always_comb begin
      hz_cnt_d = hz_cnt_q;
      if (bus.lane_valid[0] && !bus.ex_stall && !bus.flush &&
          issue_mask == '0 && hz_cnt_q != 32'hFFFF_FFFF)
         hz_cnt_d = hz_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q   <= '0;
         iss_valid_q <= '0;
         iss_we_q    <= '0;
         iss_rs1_q   <= '0;
         iss_rs2_q   <= '0;
         iss_rd_q    <= '0;
         hz_cnt_q    <= '0;
      end else begin
         pending_q   <= pending_d;
         iss_valid_q <= iss_valid_d;
         iss_we_q    <= iss_we_d;
         iss_rs1_q   <= iss_rs1_d;
         iss_rs2_q   <= iss_rs2_d;
         iss_rd_q    <= iss_rd_d;
         hz_cnt_q    <= hz_cnt_d;
      end
   end

   assign bus.issue_cnt        = issue_cnt;
   assign bus.iss_valid        = iss_valid_q;
   assign bus.iss_we           = iss_we_q;
   assign bus.iss_rs1          = iss_rs1_q;
   assign bus.iss_rs2          = iss_rs2_q;
   assign bus.iss_rd           = iss_rd_q;
   assign bus.pending          = pending_q;
   assign bus.hazard_stall_cnt = hz_cnt_q;

endmodule
